img_rom_arbiter: RTL
====================

Name: img_rom_arbiter

Overview:
- Shares the single-port image ROM (15-bit address, 8-bit data) between two requesters: the VGA sprite fetch (display port) and the decrypter fetch (decrypter port).
- Replaces the static mux that hard-selects the decrypter address.
- Display has priority during active video; the decrypter has priority during blanking.
- A starvation counter guarantees decrypter progress. Read data is routed back to the issuing port with a per-port valid strobe.

Parameters:
- AW, 15, ROM address width.
- DW, 8, ROM data width.
- RD_LAT, 1, ROM read latency in clk cycles, from the rom_en edge to valid rom_dout; legal range 1..4.
- MAX_WAIT, 16, consecutive denied decrypter cycles before a forced decrypter grant; legal range 1..255.

Ports:
- clk  in  1  single clock, 25 MHz pixel clock domain.
- rst  in  1  asynchronous, active-low reset.
- blank  in  1  VGA blanking indicator, synchronous to clk.
- disp_req  in  1  display read request; hold with disp_addr until granted.
- disp_addr  in  AW  display read address.
- disp_gnt  out  1  combinational grant; the request is accepted on a clk edge where req&gnt=1.
- disp_rvalid  out  1  one-cycle strobe: disp_rdata is valid.
- disp_rdata  out  DW  read data for the display port.
- dec_req  in  1  decrypter read request; same rules as disp_req.
- dec_addr  in  AW  decrypter read address.
- dec_gnt  out  1  decrypter grant.
- dec_rvalid  out  1  decrypter data-valid strobe.
- dec_rdata  out  DW  read data for the decrypter port.
- rom_en  out  1  registered ROM read enable.
- rom_addr  out  AW  registered ROM address.
- rom_dout  in  DW  ROM read data.
- dec_starved  out  1  registered; high while the wait counter equals MAX_WAIT.

Behaviour:
- Reset (rst=0, asynchronous): outputs are forced as follows:
  - rom_en, rom_addr, disp_rvalid, dec_rvalid, disp_rdata, dec_rdata, dec_starved all 0.
  - Tag pipeline cleared; wait counter 0.
  - In-flight reads are discarded; no rvalid is emitted after reset release for pre-reset grants.
  - Grants are 0 while rst=0.
- Arbitration (combinational; at most one grant per cycle):
  - blank=1: dec_req wins, else disp_req.
  - blank=0 and wait counter==MAX_WAIT: dec_req wins.
  - blank=0 otherwise: disp_req wins, else dec_req.
  - No request: no grant, rom_en=0 next cycle.
- Issue: on an edge with an accepted grant, rom_addr <= granted address, rom_en <= 1, and the tag (0=disp, 1=dec) enters a valid/tag shift register of depth RD_LAT+1. Otherwise rom_en <= 0 and rom_addr holds its value.
- Return:
  - When a tag exits the shift register (RD_LAT cycles after rom_en), rom_dout is registered into the tagged port's rdata, and that port's rvalid is high for exactly one cycle.
  - The other port's rdata holds its value.
- Latency: request accepted at edge E0 -> rvalid high in the cycle after edge E0+RD_LAT+1. For RD_LAT=1, that is 2 cycles after the accepting edge.
- Throughput: one read per cycle total; back-to-back grants to either port are allowed.
- Order: responses return in issue order and never reorder.
- Wait counter:
  - Increments each edge with dec_req=1 and dec_gnt=0; saturates at MAX_WAIT.
  - Clears on an edge where dec_req&dec_gnt, or where dec_req=0.
  - Width is the minimum needed to hold MAX_WAIT.
  - dec_starved is the registered compare of the counter against MAX_WAIT.
- Forced grant: the forced decrypter slot lasts exactly one accepted request, then the counter clears and display priority resumes. A simultaneous disp_req is denied that cycle and must hold.
- Simultaneous events:
  - blank toggling mid-stream affects only the next arbitration decision.
  - A request deasserted before grant is legal and is simply dropped, with no issue.
- Address stability: the address is sampled only on the accepting edge. Changes while ungranted are allowed.

Test Plan:
- Reset mid-flight: disp granted addr 0x0010, rst pulsed low for 1 cycle the next cycle -> all outputs 0 immediately, no disp_rvalid after release.
- Active video, both requesting continuously, MAX_WAIT=16, RD_LAT=1 -> 16 consecutive disp grants, then 1 dec grant, repeating. dec_starved is high on the cycle of each forced grant, and that grant clears it.
- blank=1, both requesting, disp_addr=0x0100, dec_addr=0x4ABC -> dec_gnt every cycle, rom_addr=0x4ABC, dec_rvalid with rom_dout value 0xA5 exactly 2 cycles after each accepting edge, disp_gnt=0.
- Alternating single requests disp 0x0001, dec 0x0002, disp 0x0003 on consecutive cycles, ROM model returns addr[7:0] -> rvalid sequence disp/dec/disp with rdata 0x01, 0x02, 0x03, in order, no gaps.
- RD_LAT=3: single disp read of 0x7FFF -> disp_rvalid 4 cycles after the accepting edge, rdata 0xFF.
- dec_req asserted 10 cycles, then dropped before grant during active video -> wait counter returns to 0, no dec issue, dec_starved stays 0.

Source files
------------

// File: rtl/img_rom_arbiter_if.sv
// Bundles the image-ROM arbiter's requester, ROM and status signals.
// The slave modport is the arbiter; the master modport is its environment.
interface img_rom_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 8
);
  logic          blank;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          dec_req;
  logic [AW-1:0] dec_addr;
  logic          dec_gnt;
  logic          dec_rvalid;
  logic [DW-1:0] dec_rdata;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic          dec_starved;

  modport slave (
    input  blank, disp_req, disp_addr, dec_req, dec_addr, rom_dout,
    output disp_gnt, disp_rvalid, disp_rdata, dec_gnt, dec_rvalid, dec_rdata,
           rom_en, rom_addr, dec_starved
  );

  modport master (
    output blank, disp_req, disp_addr, dec_req, dec_addr, rom_dout,
    input  disp_gnt, disp_rvalid, disp_rdata, dec_gnt, dec_rvalid, dec_rdata,
           rom_en, rom_addr, dec_starved
  );
endinterface

// File: rtl/img_rom_arbiter.sv
// Shares the single-port image ROM between the display sprite fetch and the
// decrypter, with blanking-based priority and a decrypter starvation guard.
module img_rom_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  img_rom_arbiter_if.slave bus
);
  localparam int CW    = $clog2(MAX_WAIT + 1);
  localparam int DEPTH = RD_LAT + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic          disp_gnt_s;
  logic          dec_gnt_s;
  logic          dec_first_s;
  logic          disp_acc_s;
  logic          dec_acc_s;
  logic [CW-1:0] wait_cnt_r;
  logic [CW-1:0] wait_cnt_nxt_s;
  logic          dec_starved_r;
  logic          rom_en_r;
  logic [AW-1:0] rom_addr_r;
  logic [DEPTH-1:0] pipe_vld_r;
  logic [DEPTH-1:0] pipe_tag_r;
  logic          exit_vld_s;
  logic          exit_tag_s;
  logic          disp_rvalid_r;
  logic          dec_rvalid_r;
  logic [DW-1:0] disp_rdata_r;
  logic [DW-1:0] dec_rdata_r;

  // Priority arbitration: decrypter first in blanking or when starved.
  always_comb begin
    disp_gnt_s  = 1'b0;
    dec_gnt_s   = 1'b0;
    dec_first_s = bus.blank || (wait_cnt_r == MAX_CNT);
    if (!rst) begin
      disp_gnt_s = 1'b0;
      dec_gnt_s  = 1'b0;
    end else if (dec_first_s) begin
      if (bus.dec_req) begin
        dec_gnt_s = 1'b1;
      end else begin
        disp_gnt_s = bus.disp_req;
      end
    end else begin
      if (bus.disp_req) begin
        disp_gnt_s = 1'b1;
      end else begin
        dec_gnt_s = bus.dec_req;
      end
    end
  end

  assign disp_acc_s = bus.disp_req && disp_gnt_s;
  assign dec_acc_s  = bus.dec_req && dec_gnt_s;

  // Wait counter next value: count denied decrypter cycles, saturating.
  always_comb begin
    wait_cnt_nxt_s = wait_cnt_r;
    if (!bus.dec_req || dec_gnt_s) begin
      wait_cnt_nxt_s = {CW{1'b0}};
    end else if (wait_cnt_r == MAX_CNT) begin
      wait_cnt_nxt_s = wait_cnt_r;
    end else begin
      wait_cnt_nxt_s = wait_cnt_r + CW'(1);
    end
  end

  // Wait counter and starvation flag; the flag tracks the counter's new value
  // so it is high in the same cycle the forced grant is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r    <= {CW{1'b0}};
      dec_starved_r <= 1'b0;
    end else begin
      wait_cnt_r    <= wait_cnt_nxt_s;
      dec_starved_r <= (wait_cnt_nxt_s == MAX_CNT);
    end
  end

  // ROM issue register: address only moves on an accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_en_r   <= 1'b0;
      rom_addr_r <= {AW{1'b0}};
    end else begin
      rom_en_r <= disp_acc_s || dec_acc_s;
      if (disp_acc_s) begin
        rom_addr_r <= bus.disp_addr;
      end else if (dec_acc_s) begin
        rom_addr_r <= bus.dec_addr;
      end else begin
        rom_addr_r <= rom_addr_r;
      end
    end
  end

  // Valid/tag pipeline matching ROM latency (tag 1 = decrypter).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld_r <= {DEPTH{1'b0}};
      pipe_tag_r <= {DEPTH{1'b0}};
    end else begin
      pipe_vld_r <= {pipe_vld_r[DEPTH-2:0], disp_acc_s || dec_acc_s};
      pipe_tag_r <= {pipe_tag_r[DEPTH-2:0], dec_acc_s};
    end
  end

  assign exit_vld_s = pipe_vld_r[RD_LAT];
  assign exit_tag_s = pipe_tag_r[RD_LAT];

  // Return path: capture ROM data into the tagged port only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_rvalid_r <= 1'b0;
      dec_rvalid_r  <= 1'b0;
      disp_rdata_r  <= {DW{1'b0}};
      dec_rdata_r   <= {DW{1'b0}};
    end else begin
      disp_rvalid_r <= exit_vld_s && !exit_tag_s;
      dec_rvalid_r  <= exit_vld_s && exit_tag_s;
      if (exit_vld_s && !exit_tag_s) begin
        disp_rdata_r <= bus.rom_dout;
      end else begin
        disp_rdata_r <= disp_rdata_r;
      end
      if (exit_vld_s && exit_tag_s) begin
        dec_rdata_r <= bus.rom_dout;
      end else begin
        dec_rdata_r <= dec_rdata_r;
      end
    end
  end

  assign bus.disp_gnt    = disp_gnt_s;
  assign bus.dec_gnt     = dec_gnt_s;
  assign bus.rom_en      = rom_en_r;
  assign bus.rom_addr    = rom_addr_r;
  assign bus.disp_rvalid = disp_rvalid_r;
  assign bus.dec_rvalid  = dec_rvalid_r;
  assign bus.disp_rdata  = disp_rdata_r;
  assign bus.dec_rdata   = dec_rdata_r;
  assign bus.dec_starved = dec_starved_r;
endmodule
